// File: rtl/imem_access_arbiter.sv
// Purpose : shares the single instruction-memory port between CPU fetch (read-only) and the
//           firmware loader/debug port (read/write). Fetch has fixed priority. A loader that has
//           waited MAX_WAIT cycles gets the next cycle.
// Latency : grant and memory pins are combinational in cycle N. The response (rvalid/rdata/err)
//           comes in cycle N+1. One access per cycle, fully pipelined.
// Backpr. : req/gnt handshake. A requester holds req and its payload until gnt. There is no
//           response backpressure.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   fetch_req/addr -> fetch_gnt      fetch read request and same-cycle grant
//   fetch_rvalid/rdata               fetch read response, cycle after grant
//   ld_req/we/addr/wdata/wstrb       loader request (we=1 write)
//   ld_gnt, ld_rvalid/rdata/err      loader grant and response (write ack has rdata=0)
//   wr_lock                          MPU write protect (used only with IMEM_WRITE_LOCK_EN)
//   mem_we/addr/wdata/wstrb          memory pins, driven from the granted requester
//   mem_rdata                        memory read data, valid the cycle after the address
//
// Build option: define IMEM_WRITE_LOCK_EN to make loader writes granted while wr_lock=1
// complete as blocked writes (mem_we=0) that return an error response.
module imem_access_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic [3:0]        ld_wstrb,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              ld_err,
  input  logic              wr_lock,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] RSP_IDLE   = 3'd0;
  localparam logic [2:0] RSP_FETCH  = 3'd1;
  localparam logic [2:0] RSP_LD_RD  = 3'd2;
  localparam logic [2:0] RSP_LD_WR  = 3'd3;
  localparam logic [2:0] RSP_LD_ERR = 3'd4;

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_starve_cnt;
  logic [2:0] r_rsp_state;
  logic [2:0] w_rsp_next;
  logic       w_ld_force;
  logic       w_ld_gnt;
  logic       w_fetch_gnt;
  logic       w_blocked;

  // The loader wins when fetch is idle, or when it has already lost MAX_WAIT cycles in a row.
  // Grants are masked during reset, so every output stays 0 while rst_n is low, even if a
  // requester keeps req high.
  assign w_ld_force  = (r_starve_cnt == C_MAX_WAIT);
  assign w_ld_gnt    = rst_n & ld_req & (~fetch_req | w_ld_force);
  assign w_fetch_gnt = rst_n & fetch_req & ~w_ld_gnt;

`ifdef IMEM_WRITE_LOCK_EN
  // wr_lock matters only in the cycle a loader write is granted.
  assign w_blocked = w_ld_gnt & ld_we & wr_lock;
`else
  logic w_unused_wr_lock;
  assign w_unused_wr_lock = wr_lock;
  assign w_blocked        = 1'b0;
`endif

  assign fetch_gnt = w_fetch_gnt;
  assign ld_gnt    = w_ld_gnt;

  // Memory pins follow the granted requester. All pins are 0 when nothing is granted.
  // A zero strobe still goes out as a write with mem_we=1. The memory treats it as a no-op
  // and the loader still gets a normal ack.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (w_ld_gnt) begin
      mem_we    = ld_we & ~w_blocked;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_wstrb = ld_wstrb;
    end else if (w_fetch_gnt) begin
      mem_addr  = fetch_addr;
    end
  end

  // The next response type is decided only by this cycle's grant. Back-to-back grants
  // therefore give continuous rvalid.
  always_comb begin
    w_rsp_next = RSP_IDLE;
    if (w_ld_gnt) begin
      if (!ld_we)        w_rsp_next = RSP_LD_RD;
      else if (w_blocked) w_rsp_next = RSP_LD_ERR;
      else               w_rsp_next = RSP_LD_WR;
    end else if (w_fetch_gnt) begin
      w_rsp_next = RSP_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_state  <= RSP_IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_rsp_state <= w_rsp_next;
      // Count cycles in which a pending loader request loses to fetch. The count cannot pass
      // MAX_WAIT, because reaching MAX_WAIT forces a loader grant that clears it.
      if (!ld_req || w_ld_gnt)
        r_starve_cnt <= 4'd0;
      else if (fetch_req && !w_ld_force)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Response outputs come straight from the state and the memory read port.
  // They are 0 whenever not valid.
  assign fetch_rvalid = (r_rsp_state == RSP_FETCH);
  assign fetch_rdata  = fetch_rvalid ? mem_rdata : 32'd0;
  assign ld_rvalid    = (r_rsp_state == RSP_LD_RD) || (r_rsp_state == RSP_LD_WR) ||
                        (r_rsp_state == RSP_LD_ERR);
  assign ld_rdata     = (r_rsp_state == RSP_LD_RD) ? mem_rdata : 32'd0;

`ifdef IMEM_WRITE_LOCK_EN
  assign ld_err = (r_rsp_state == RSP_LD_ERR);
`else
  assign ld_err = 1'b0;
`endif

endmodule
